vend_ctrl: RTL and testbench

Credit-and-dispense controller for the vending machine. It edge-detects the nickel/dime buttons and accumulates credit in nickel units. When credit reaches the configured price it runs a request/acknowledge handshake with the product dispenser. It then returns change one nickel at a time through a second handshake with the coin-return mechanism; a cancel button refunds all credit through the same change path.

---
 rtl/vend_pkg.sv | 18 +
 rtl/vend_ctrl_btn_edge.sv | 20 ++
 rtl/vend_ctrl.sv | 133 +++++++++++++
 tb/tb_vend_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit/dispense controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int NICKEL_N = 1;
  localparam int DIME_N   = 2;

  // Price expressed in nickel units.
  function automatic int price_n(input int price_cents);
    return price_cents / 5;
  endfunction

endpackage

// File: rtl/vend_ctrl_btn_edge.sv
// Rising-edge detector for a coin button level. The previous-sample flop
// resets to 1 so a button already held when reset releases is not counted.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember last cycle's button level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b1;
    else      prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/vend_ctrl.sv
// Credit-and-dispense controller: accumulates nickel/dime credit, runs the
// dispenser handshake once the price is reached, then pays change back one
// nickel at a time. Cancel refunds all credit through the change path.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_CENTS = 25,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nb,
  input  logic          db,
  input  logic          cancel,
  input  logic          disp_ack,
  input  logic          chg_ack,
  output logic          s,
  output logic          r,
  output logic [CW-1:0] credit,
  output logic          coin_rej,
  output logic [1:0]    state
);

  localparam int PRICE_N    = price_n(PRICE_CENTS);
  localparam int MAX_CREDIT = (1 << CW) - 1;
  localparam int SW         = CW + 2;
  localparam logic [CW-1:0] PRICE_V = CW'(PRICE_N);
  localparam logic [SW-1:0] MAX_V   = SW'(MAX_CREDIT);

  // A price that is not a whole number of nickels, or that the credit
  // register cannot hold, would make the machine unable to ever vend.
  if ((PRICE_CENTS % 5) != 0 || PRICE_N < 1 || PRICE_N > MAX_CREDIT) begin : g_bad_price
    $error("vend_ctrl: PRICE_CENTS must be a multiple of 5 and fit in CW nickels");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          rej_q, rej_d;
  logic          nb_rise, db_rise, coin_any, fits;
  logic [1:0]    coin_val;
  logic [SW-1:0] sum;

  btn_edge u_nb_edge (
    .clk   (clk),
    .rst   (rst),
    .level (nb),
    .rise  (nb_rise)
  );

  btn_edge u_db_edge (
    .clk   (clk),
    .rst   (rst),
    .level (db),
    .rise  (db_rise)
  );

  // Value of this cycle's coin edges, and whether it fits in the register.
  always_comb begin
    coin_val = '0;
    if (nb_rise) coin_val = coin_val + 2'(NICKEL_N);
    if (db_rise) coin_val = coin_val + 2'(DIME_N);
    coin_any = nb_rise | db_rise;
    sum      = {2'b00, credit_q} + SW'(coin_val);
    fits     = (sum <= MAX_V);
  end

  // State, credit and reject-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
    end
  end

  // Next state, credit arithmetic and coin rejection. Coins are only
  // credited while idling with no transition pending.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (credit_q >= PRICE_V) begin
          state_d  = VEND;
          credit_d = credit_q - PRICE_V;
          rej_d    = coin_any;
        end else if (cancel && credit_q != '0) begin
          state_d = CHANGE;
          rej_d   = coin_any;
        end else if (coin_any) begin
          if (fits) credit_d = credit_q + CW'(coin_val);
          else      rej_d    = 1'b1;
        end
      end
      VEND: begin
        rej_d = coin_any;
        if (disp_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = coin_any;
        if (chg_ack) begin
          credit_d = credit_q - CW'(1);
          if (credit_q == CW'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Handshake requests decoded from the state register alone.
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    case (state_q)
      VEND:    s = 1'b1;
      CHANGE:  r = 1'b1;
      default: ;
    endcase
  end

  assign state    = state_q;
  assign credit   = credit_q;
  assign coin_rej = rej_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: one instance priced at 25c, one at 75c, checked every
// cycle against a rule-level model plus hand-computed checkpoints.
module tb_vend_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic a_nb, a_db, a_cancel, a_dack, a_cack;
  logic a_s, a_r, a_rej;
  logic [3:0] a_credit;
  logic [1:0] a_state;

  logic b_nb, b_db, b_cancel, b_dack, b_cack;
  logic b_s, b_r, b_rej;
  logic [3:0] b_credit;
  logic [1:0] b_state;

  int compared   = 0;
  int mismatched = 0;

  localparam int M_IDLE   = 0;
  localparam int M_VEND   = 1;
  localparam int M_CHANGE = 2;

  typedef struct {
    int st;
    int cr;
    bit rej;
    bit pn;
    bit pd;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE_CENTS(25), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .nb(a_nb), .db(a_db), .cancel(a_cancel),
    .disp_ack(a_dack), .chg_ack(a_cack), .s(a_s), .r(a_r),
    .credit(a_credit), .coin_rej(a_rej), .state(a_state)
  );

  vend_ctrl #(.PRICE_CENTS(75), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .nb(b_nb), .db(b_db), .cancel(b_cancel),
    .disp_ack(b_dack), .chg_ack(b_cack), .s(b_s), .r(b_r),
    .credit(b_credit), .coin_rej(b_rej), .state(b_state)
  );

  function automatic mdl_t model_reset();
    mdl_t m;
    m.st = M_IDLE; m.cr = 0; m.rej = 1'b0; m.pn = 1'b1; m.pd = 1'b1;
    return m;
  endfunction

  // One clock edge of the machine described as plain credit arithmetic.
  function automatic mdl_t model_step(input mdl_t m, input logic nb, input logic db,
                                      input logic cn, input logic da, input logic ca,
                                      input int price, input int max_cr);
    mdl_t n = m;
    int add = 0;
    if (nb && !m.pn) add += 1;
    if (db && !m.pd) add += 2;
    n.pn  = nb;
    n.pd  = db;
    n.rej = (add > 0);
    if (m.st == M_IDLE) begin
      if (m.cr >= price) begin
        n.st = M_VEND;
        n.cr = m.cr - price;
      end else if (cn && m.cr > 0) begin
        n.st = M_CHANGE;
      end else if (m.cr + add <= max_cr) begin
        n.cr  = m.cr + add;
        n.rej = 1'b0;
      end
    end else if (m.st == M_VEND) begin
      if (da) n.st = (m.cr > 0) ? M_CHANGE : M_IDLE;
    end else begin
      if (ca) begin
        n.cr = m.cr - 1;
        if (n.cr == 0) n.st = M_IDLE;
      end
    end
    return n;
  endfunction

  // Advance both models alongside the DUTs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, a_nb, a_db, a_cancel, a_dack, a_cack, 5, 15);
      mb <= model_step(mb, b_nb, b_db, b_cancel, b_dack, b_cack, 15, 15);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the models.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check_output("a_state", 32'(a_state), 32'(ma.st));
      check_output("a_credit", 32'(a_credit), 32'(ma.cr));
      check_output("a_s", 32'(a_s), 32'(ma.st == M_VEND));
      check_output("a_r", 32'(a_r), 32'(ma.st == M_CHANGE));
      check_output("a_coin_rej", 32'(a_rej), 32'(ma.rej));
      check_output("b_state", 32'(b_state), 32'(mb.st));
      check_output("b_credit", 32'(b_credit), 32'(mb.cr));
      check_output("b_s", 32'(b_s), 32'(mb.st == M_VEND));
      check_output("b_r", 32'(b_r), 32'(mb.st == M_CHANGE));
      check_output("b_coin_rej", 32'(b_rej), 32'(mb.rej));
    end
  end

  // Drive one cycle of inputs on unit u, then settle just past the edge.
  task automatic apply_stimulus(input int u, input logic nb, input logic db,
                                input logic cn, input logic da, input logic ca);
    @(negedge clk);
    if (u == 0) begin
      a_nb = nb; a_db = db; a_cancel = cn; a_dack = da; a_cack = ca;
    end else begin
      b_nb = nb; b_db = db; b_cancel = cn; b_dack = da; b_cack = ca;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int u, input logic nb, input logic db);
    apply_stimulus(u, nb, db, 1'b0, 1'b0, 1'b0);
    apply_stimulus(u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    a_nb = 0; a_db = 0; a_cancel = 0; a_dack = 0; a_cack = 0;
    b_nb = 0; b_db = 0; b_cancel = 0; b_dack = 0; b_cack = 0;
    #3;
    check_output("rst_a_state", 32'(a_state), 0);
    check_output("rst_a_credit", 32'(a_credit), 0);
    check_output("rst_a_s", 32'(a_s), 0);
    check_output("rst_a_r", 32'(a_r), 0);
    check_output("rst_b_coin_rej", 32'(b_rej), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Five nickels at 25c: vend with nothing left over.
    for (int i = 0; i < 5; i++) press(0, 1'b1, 1'b0);
    check_output("t1_state_vend", 32'(a_state), 1);
    check_output("t1_s", 32'(a_s), 1);
    check_output("t1_credit", 32'(a_credit), 0);
    // Dime while vending is rejected.
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t4_rej", 32'(a_rej), 1);
    check_output("t4_credit", 32'(a_credit), 0);
    check_output("t4_still_vend", 32'(a_state), 1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t1_idle", 32'(a_state), 0);
    check_output("t1_s_low", 32'(a_s), 0);
    check_output("t1_r_low", 32'(a_r), 0);
    check_output("t4_rej_done", 32'(a_rej), 0);

    // 35c: dime, dime, then nickel+dime together -> vend with 2 nickels due.
    press(0, 1'b0, 1'b1);
    press(0, 1'b0, 1'b1);
    check_output("t2_credit4", 32'(a_credit), 4);
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t2_credit7", 32'(a_credit), 7);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t2_vend_credit", 32'(a_credit), 2);
    check_output("t2_s", 32'(a_s), 1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t2_r", 32'(a_r), 1);
    check_output("t2_s_off", 32'(a_s), 0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t2_credit1", 32'(a_credit), 1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t2_credit0", 32'(a_credit), 0);
    check_output("t2_idle", 32'(a_state), 0);

    // Nickel + dime, then cancel: refund 3 nickels with chg_ack held.
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("t3_r", 32'(a_r), 1);
    check_output("t3_credit", 32'(a_credit), 3);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t3_credit0", 32'(a_credit), 0);
    check_output("t3_idle", 32'(a_state), 0);
    check_output("t3_r_off", 32'(a_r), 0);

    // Nickel held for 10 cycles counts once.
    for (int i = 0; i < 10; i++) apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t4_held_once", 32'(a_credit), 1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t4_cleanup", 32'(a_state), 0);

    // 75c unit: fill to 14 nickels, then probe the overflow boundary.
    for (int i = 0; i < 7; i++) press(1, 1'b0, 1'b1);
    check_output("t5_credit14", 32'(b_credit), 14);
    apply_stimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t5_dime_rej", 32'(b_rej), 1);
    check_output("t5_dime_credit", 32'(b_credit), 14);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t6_both_rej", 32'(b_rej), 1);
    check_output("t6_both_credit", 32'(b_credit), 14);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t7_credit15", 32'(b_credit), 15);
    check_output("t7_rej_none", 32'(b_rej), 0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t7_vend", 32'(b_state), 1);
    check_output("t7_credit0", 32'(b_credit), 0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t7_idle", 32'(b_state), 0);

    // Reset in the middle of a refund with 2 nickels still due.
    apply_stimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("t8_change", 32'(b_state), 2);
    check_output("t8_credit2", 32'(b_credit), 2);
    @(negedge clk);
    b_cancel = 1'b0;
    b_nb = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_output("t8_rst_state", 32'(b_state), 0);
    check_output("t8_rst_credit", 32'(b_credit), 0);
    check_output("t8_rst_r", 32'(b_r), 0);
    check_output("t8_rst_s", 32'(b_s), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t8_held_not_counted", 32'(b_credit), 0);
    check_output("t8_no_rej", 32'(b_rej), 0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t8_fresh_nickel", 32'(b_credit), 1);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
